out_port_fifo_bank: RTL and testbench
=====================================

// Module: out_port_fifo_bank
// PURPOSE
//  Parametrised output unit for the microprocessor. Generalises the single 4-bit output register to
//  NCH output channels, each WIDTH bits wide and backed by a DEPTH-entry FIFO.
//  Sits between the internal bus (IB) / control unit and external consumers.
//  Decouples CPU writes (LoadOut) from per-channel consumers via a valid/ack handshake.
// PARAMETERS
//  WIDTH  4  data bits per channel (>=1)
//  NCH    2  number of output channels (>=1)
//  DEPTH  4  FIFO entries per channel (power of 2, >=2)
//  CW     max(1,$clog2(NCH))  derived; channel-select width (localparam)
// PORTS
//  MainClock     in   1          single clock; all state updates on rising edge
//  invMainReset  in   1          asynchronous, active-low reset
//  IB            in   WIDTH      internal bus data to write
//  LoadOut       in   1          write strobe; sampled on rising MainClock
//  ChanSel       in   CW         target channel for the write
//  OutFull       out  NCH        per-channel FIFO full (count==DEPTH)
//  OutOvf        out  NCH        sticky overflow: write attempted while full
//  ClrOvf        in   1          clears OutOvf[ChanSel] (synchronous)
//  Out           out  NCH*WIDTH  head data per channel; channel c at [c*WIDTH +: WIDTH]
//  OutValid      out  NCH        channel c holds >=1 entry
//  OutAck        in   NCH        consumer accepts head of channel c
// BEHAVIOUR
//  - Reset (invMainReset=0, async): all counts/pointers 0, Out=0, OutValid=0, OutFull=0, OutOvf=0.
//    Reset mid-operation discards all queued data immediately; no partial writes survive.
//  - Push: LoadOut=1 && ChanSel<NCH && !OutFull[ChanSel] -> IB enqueued into channel ChanSel.
//    ChanSel>=NCH: write ignored, no flag set.
//  - Push on full: data dropped, OutOvf[ChanSel] set the same edge. This holds even when OutAck
//    pops that channel in the same cycle (full is evaluated pre-edge; deterministic drop).
//  - Pop: OutValid[c] && OutAck[c] -> head advances. OutAck on an empty channel is ignored.
//  - Simultaneous push+pop on a non-full, non-empty channel: count unchanged, both take effect.
//  - Push into empty channel with concurrent OutAck: ack ignored (OutValid was 0); entry queued.
//  - Latency: write at edge k -> OutValid=1 and Out=data visible after edge k (1 cycle).
//    Pop at edge k -> next entry on Out after edge k.
//  - Out shows head entry (show-ahead). When empty, Out holds its last value; consumers must qualify
//    with OutValid. After reset it is 0.
//  - Ordering: strict FIFO per channel; channels fully independent; all pops can occur in one cycle.
//  - Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count: log2(DEPTH)+1 bits, 0..DEPTH.
//    OutFull = (count==DEPTH), OutValid = (count!=0), both registered-state derived.
//  - ClrOvf && overflow on the same channel, same edge: set wins (OutOvf stays 1).
// STRUCTURE
//  - Shared package out_port_pkg: default WIDTH/NCH/DEPTH constants, clog2 helper, channel-index
//    slicing macro/function.
//  - Sub-module out_chan_fifo (WIDTH, DEPTH): one channel's storage, pointers, count, valid/full,
//    overflow flag. Top instantiates NCH copies via generate.
//  - Top contains only ChanSel decode, per-channel push/clear enables, and Out/flag concatenation.
// TESTING
//  1 Reset: drive invMainReset=0 mid-stream with 3 entries queued -> Out=0, OutValid=0, OutFull=0,
//    OutOvf=0 immediately (async); after release the first push is the only entry visible.
//  2 Basic write: ChanSel=1, IB=4'hA, LoadOut 1 cycle -> OutValid=2'b10, Out[7:4]=4'hA next cycle;
//    OutAck[1] 1 cycle -> OutValid[1]=0.
//  3 Fill/overflow: push 5,6,7,8 to ch0 -> OutFull[0]=1; push 9 -> dropped, OutOvf[0]=1;
//    drain yields 5,6,7,8 in order; ClrOvf with ChanSel=0 -> OutOvf[0]=0.
//  4 Full+pop same cycle: ch0 full, push 4'hF with OutAck[0]=1 -> count becomes 3, F not queued,
//    OutOvf[0]=1.
//  5 Concurrency: ch0 has 2 entries, push ch0 + ack ch0 + ack ch1 (ch1 empty) -> ch0 count stays 2,
//    head advances; ch1 unaffected.
//  6 Wrap-around: 3*DEPTH push/pop cycles on ch1 with values 0..11 -> exact order preserved,
//    no spurious full/valid.

Source files
------------

// File: rtl/out_port_pkg.sv
// Shared constants and helpers for the output-port FIFO bank.
package out_port_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_NCH   = 2;
    localparam int unsigned DEF_DEPTH = 4;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest bit of channel c inside a flattened NCH*width bus.
    function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned width);
        return c * width;
    endfunction

endpackage

// File: rtl/out_chan_fifo.sv
// One output channel: show-ahead FIFO with registered head, valid/full and sticky overflow.
module out_chan_fifo
    import out_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             clr_ovf_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             ovf_o
);

    localparam int unsigned PW   = clog2_min1(DEPTH);
    localparam int unsigned CNTW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d, full_q, full_d, ovf_q, ovf_d;
    logic             do_push, do_pop;

    // Full and valid come from pre-edge state, so a push on full drops even if popped this edge.
    always_comb begin
        do_push = push_i && !full_q;
        do_pop  = pop_i && valid_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        ovf_d   = ovf_q;

        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);

        if (do_push && !do_pop)      cnt_d = cnt_q + CNTW'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - CNTW'(1);

        if (do_push && (cnt_q == '0)) begin
            head_d = data_i;
        end else if (do_pop) begin
            if (cnt_q > CNTW'(1)) head_d = mem_q[rd_q + PW'(1)];
            else if (do_push)     head_d = data_i;
        end

        if (push_i && full_q) ovf_d = 1'b1;
        else if (clr_ovf_i)   ovf_d = 1'b0;

        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == CNTW'(DEPTH));
    end

    // Storage needs no reset: nothing is readable until the count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/out_port_fifo_bank.sv
// NCH-channel output unit: decodes CPU writes onto per-channel FIFOs drained by valid/ack consumers.
module out_port_fifo_bank
    import out_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CW   = clog2_min1(NCH)
) (
    input  logic                 MainClock,
    input  logic                 invMainReset,
    input  logic [WIDTH-1:0]     IB,
    input  logic                 LoadOut,
    input  logic [CW-1:0]        ChanSel,
    output logic [NCH-1:0]       OutFull,
    output logic [NCH-1:0]       OutOvf,
    input  logic                 ClrOvf,
    output logic [NCH*WIDTH-1:0] Out,
    output logic [NCH-1:0]       OutValid,
    input  logic [NCH-1:0]       OutAck
);

    logic [NCH-1:0] push_en;
    logic [NCH-1:0] clr_en;

    // Selects beyond NCH-1 match no channel and are silently ignored.
    always_comb begin
        push_en = '0;
        clr_en  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            push_en[c] = LoadOut && (ChanSel == CW'(c));
            clr_en[c]  = ClrOvf  && (ChanSel == CW'(c));
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        out_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (MainClock),
            .rst_n     (invMainReset),
            .push_i    (push_en[c]),
            .data_i    (IB),
            .pop_i     (OutAck[c]),
            .clr_ovf_i (clr_en[c]),
            .head_o    (Out[chan_lsb(c, WIDTH) +: WIDTH]),
            .valid_o   (OutValid[c]),
            .full_o    (OutFull[c]),
            .ovf_o     (OutOvf[c])
        );
    end

endmodule

// File: tb/tb_out_port_fifo_bank.sv
// Randomized plus directed bench for out_port_fifo_bank against a queue-based channel model.
module tb_out_port_fifo_bank;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 1;

    logic                 MainClock = 1'b0;
    logic                 invMainReset;
    logic [WIDTH-1:0]     IB;
    logic                 LoadOut;
    logic [CW-1:0]        ChanSel;
    logic [NCH-1:0]       OutFull;
    logic [NCH-1:0]       OutOvf;
    logic                 ClrOvf;
    logic [NCH*WIDTH-1:0] Out;
    logic [NCH-1:0]       OutValid;
    logic [NCH-1:0]       OutAck;

    out_port_fifo_bank #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .MainClock    (MainClock),
        .invMainReset (invMainReset),
        .IB           (IB),
        .LoadOut      (LoadOut),
        .ChanSel      (ChanSel),
        .OutFull      (OutFull),
        .OutOvf       (OutOvf),
        .ClrOvf       (ClrOvf),
        .Out          (Out),
        .OutValid     (OutValid),
        .OutAck       (OutAck)
    );

    always #5 MainClock = ~MainClock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          chk_en   = 1'b0;

    logic [WIDTH-1:0] mq [NCH][$];
    logic [WIDTH-1:0] m_out [NCH];
    logic             m_ovf [NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_out[c] = '0;
            m_ovf[c] = 1'b0;
        end
    endtask

    // One rising edge of the specified behaviour, evaluated on the inputs held across it.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit sel, was_full;
            sel      = (int'(ChanSel) == c);
            was_full = (mq[c].size() == int'(DEPTH));
            if (OutAck[c] && mq[c].size() > 0) void'(mq[c].pop_front());
            if (LoadOut && sel && was_full) begin
                m_ovf[c] = 1'b1;
            end else begin
                if (LoadOut && sel) mq[c].push_back(IB);
                if (ClrOvf && sel)  m_ovf[c] = 1'b0;
            end
            if (mq[c].size() > 0) m_out[c] = mq[c][0];
        end
    endtask

    always @(negedge MainClock) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("cyc_out%0d", c), 32'(Out[c*WIDTH +: WIDTH]), 32'(m_out[c]));
                chk($sformatf("cyc_valid%0d", c), 32'(OutValid[c]), 32'(mq[c].size() != 0));
                chk($sformatf("cyc_full%0d", c), 32'(OutFull[c]), 32'(mq[c].size() == int'(DEPTH)));
                chk($sformatf("cyc_ovf%0d", c), 32'(OutOvf[c]), 32'(m_ovf[c]));
            end
        end
    end

    task automatic idle();
        LoadOut = 1'b0;
        ClrOvf  = 1'b0;
        OutAck  = '0;
    endtask

    task automatic cycle();
        @(posedge MainClock);
        if (invMainReset) model_edge();
        #1;
    endtask

    task automatic push(input int ch, input logic [WIDTH-1:0] d);
        LoadOut = 1'b1;
        ChanSel = CW'(ch);
        IB      = d;
        cycle();
        idle();
    endtask

    task automatic ack(input logic [NCH-1:0] a);
        OutAck = a;
        cycle();
        idle();
    endtask

    initial begin
        invMainReset = 1'b0;
        IB = '0;
        ChanSel = '0;
        idle();
        model_reset();
        #2;
        chk("rst_out", 32'(Out), 32'h0);
        chk("rst_valid", 32'(OutValid), 32'h0);
        repeat (2) cycle();
        invMainReset = 1'b1;
        chk_en = 1'b1;
        cycle();

        // Async reset with three entries queued
        push(0, 4'h1); push(0, 4'h2); push(0, 4'h3);
        chk("pre_rst_valid", 32'(OutValid), 32'h1);
        #2;
        invMainReset = 1'b0;
        model_reset();
        #1;
        chk("arst_out", 32'(Out), 32'h0);
        chk("arst_valid", 32'(OutValid), 32'h0);
        chk("arst_full", 32'(OutFull), 32'h0);
        chk("arst_ovf", 32'(OutOvf), 32'h0);
        cycle();
        invMainReset = 1'b1;
        cycle();
        push(0, 4'h7);
        chk("post_rst_head", 32'(Out[3:0]), 32'h7);
        chk("post_rst_valid", 32'(OutValid), 32'h1);
        ack(2'b01);
        chk("post_rst_drain", 32'(OutValid), 32'h0);

        // Basic write to channel 1
        push(1, 4'hA);
        chk("basic_valid", 32'(OutValid), 32'h2);
        chk("basic_out", 32'(Out[7:4]), 32'hA);
        ack(2'b10);
        chk("basic_pop", 32'(OutValid[1]), 32'h0);

        // Fill, overflow, ordered drain, clear
        push(0, 4'h5); push(0, 4'h6); push(0, 4'h7); push(0, 4'h8);
        chk("fill_full", 32'(OutFull[0]), 32'h1);
        push(0, 4'h9);
        chk("ovf_set", 32'(OutOvf[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(Out[3:0]), 32'(5 + i));
            ack(2'b01);
        end
        chk("drain_empty", 32'(OutValid[0]), 32'h0);
        ClrOvf = 1'b1; ChanSel = '0;
        cycle(); idle();
        chk("ovf_clr", 32'(OutOvf[0]), 32'h0);

        // Push on full with same-cycle pop
        push(0, 4'h1); push(0, 4'h2); push(0, 4'h3); push(0, 4'h4);
        LoadOut = 1'b1; ChanSel = '0; IB = 4'hF; OutAck = 2'b01;
        cycle(); idle();
        chk("fullpop_ovf", 32'(OutOvf[0]), 32'h1);
        chk("fullpop_notfull", 32'(OutFull[0]), 32'h0);
        chk("fullpop_head", 32'(Out[3:0]), 32'h2);
        for (int i = 0; i < 3; i++) begin
            chk("fullpop_order", 32'(Out[3:0]), 32'(2 + i));
            ack(2'b01);
        end
        chk("fullpop_empty", 32'(OutValid[0]), 32'h0);
        ClrOvf = 1'b1; ChanSel = '0;
        cycle(); idle();

        // Concurrent push/pop on ch0 while acking empty ch1
        push(0, 4'h3); push(0, 4'h4);
        LoadOut = 1'b1; ChanSel = '0; IB = 4'h5; OutAck = 2'b11;
        cycle(); idle();
        chk("conc_head", 32'(Out[3:0]), 32'h4);
        chk("conc_valid", 32'(OutValid), 32'h1);
        chk("conc_ch1_hold", 32'(Out[7:4]), 32'hA);
        ack(2'b01);
        chk("conc_next", 32'(Out[3:0]), 32'h5);
        ack(2'b01);

        // Wrap-around on ch1
        for (int i = 0; i < 3 * int'(DEPTH); i++) begin
            push(1, WIDTH'(i));
            chk("wrap_head", 32'(Out[7:4]), 32'(i));
            ack(2'b10);
            chk("wrap_empty", 32'(OutValid[1]), 32'h0);
            chk("wrap_nofull", 32'(OutFull[1]), 32'h0);
        end

        // Random traffic checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            LoadOut = ($urandom_range(0, 99) < 60);
            ChanSel = CW'($urandom_range(0, 1));
            IB      = WIDTH'($urandom);
            OutAck  = NCH'($urandom);
            ClrOvf  = ($urandom_range(0, 99) < 8);
            cycle();
        end
        idle();
        cycle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
